// File: rtl/fft16_stage_seq.sv
// Gathers a 16-sample frame, hands it in parallel to the stage-1 butterfly bank, streams results back out.
// Output is valid 2 edges after the last sample is accepted. in_ready is low in CALC/UNLOAD, and the output holds while out_ready is low.
module fft16_stage_seq #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_re,
    input  logic [WIDTH-1:0]      in_im,
    input  logic                  in_last,
    output logic [16*WIDTH-1:0]   bf_xr,
    output logic [16*WIDTH-1:0]   bf_xi,
    input  logic [16*WIDTH-1:0]   bf_yr,
    input  logic [16*WIDTH-1:0]   bf_yi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_re,
    output logic [WIDTH-1:0]      out_im,
    output logic [3:0]            out_idx,
    output logic                  out_last,
    output logic                  frame_err,
    output logic [7:0]            frame_cnt,
    output logic                  busy
);
    typedef enum logic [1:0] {S_LOAD = 2'd0, S_CALC = 2'd1, S_UNLOAD = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ire_q [16];
    logic [WIDTH-1:0] iim_q [16];
    logic [WIDTH-1:0] ore_q [16];
    logic [WIDTH-1:0] oim_q [16];
    logic [3:0]       wr_idx_q, rd_idx_q;
    logic [7:0]       frame_cnt_q;
    logic             err_q;
    logic             in_fire, out_fire, last_slot, bad_frame, frame_in, frame_out;

    assign in_fire   = in_valid && in_ready;
    assign last_slot = (wr_idx_q == 4'd15);
    // in_last must coincide exactly with the 16th slot; anything else aborts the partial frame
    assign bad_frame = in_fire && (in_last != last_slot);
    assign frame_in  = in_fire && in_last && last_slot;
    assign out_fire  = out_valid && out_ready;
    assign frame_out = out_fire && (rd_idx_q == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD:   if (frame_in) state_d = S_CALC;
                S_CALC:   state_d = S_UNLOAD;
                S_UNLOAD: if (frame_out) state_d = S_LOAD;
                default:  state_d = S_LOAD;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD);
        out_valid = (state_q == S_UNLOAD);
        busy      = (state_q != S_LOAD);
        out_idx   = rd_idx_q;
        out_last  = out_valid && (rd_idx_q == 4'd15);
        out_re    = out_valid ? ore_q[rd_idx_q] : '0;
        out_im    = out_valid ? oim_q[rd_idx_q] : '0;
    end

    assign frame_err = err_q;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                ire_q[k] <= '0;
                iim_q[k] <= '0;
                ore_q[k] <= '0;
                oim_q[k] <= '0;
            end
            wr_idx_q    <= 4'd0;
            rd_idx_q    <= 4'd0;
            frame_cnt_q <= 8'd0;
            err_q       <= 1'b0;
        end else if (clear) begin
            wr_idx_q <= 4'd0;
            rd_idx_q <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= bad_frame;
            if (in_fire) begin
                if (bad_frame) begin
                    wr_idx_q <= 4'd0;
                end else begin
                    ire_q[wr_idx_q] <= in_re;
                    iim_q[wr_idx_q] <= in_im;
                    wr_idx_q        <= wr_idx_q + 4'd1;
                end
            end
            if (state_q == S_CALC) begin
                for (int k = 0; k < 16; k++) begin
                    ore_q[k] <= bf_yr[k*WIDTH +: WIDTH];
                    oim_q[k] <= bf_yi[k*WIDTH +: WIDTH];
                end
                rd_idx_q <= 4'd0;
            end
            if (out_fire) begin
                rd_idx_q <= rd_idx_q + 4'd1;
                if (frame_out) begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_flat
        assign bf_xr[k*WIDTH +: WIDTH] = ire_q[k];
        assign bf_xi[k*WIDTH +: WIDTH] = iim_q[k];
    end

endmodule
